// File: rtl/rv_pkg.sv
// Shared RV32 decode constants and the packed control bundle carried through ID/EX.
package rv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  typedef struct packed {
    logic [1:0] ALUop;
    logic       Branch;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic       MemToReg;
    logic       ALUsrc;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// Decode-side inputs and execute-side outputs of the ID/EX pipeline register.
interface id_ex_stage_reg_if #(
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5
);
  logic                 id_valid;
  logic [6:0]           id_opcode;
  logic [1:0]           id_ALUop;
  logic                 id_Branch, id_MemRead, id_MemWrite, id_RegWrite, id_MemToReg, id_ALUsrc;
  logic [XLEN-1:0]      id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [REG_IDX_W-1:0] id_rs1, id_rs2, id_rd;
  logic [2:0]           id_funct3;
  logic                 id_funct7b5;
  logic                 flush;
  logic                 stall;
  logic                 ex_valid;
  logic [1:0]           ex_ALUop;
  logic                 ex_Branch, ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemToReg, ex_ALUsrc;
  logic [XLEN-1:0]      ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [REG_IDX_W-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0]           ex_funct3;
  logic                 ex_funct7b5;

  modport master (
    output id_valid, id_opcode, id_ALUop, id_Branch, id_MemRead, id_MemWrite, id_RegWrite,
           id_MemToReg, id_ALUsrc, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2,
           id_rd, id_funct3, id_funct7b5, flush,
    input  stall, ex_valid, ex_ALUop, ex_Branch, ex_MemRead, ex_MemWrite, ex_RegWrite,
           ex_MemToReg, ex_ALUsrc, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
           ex_rd, ex_funct3, ex_funct7b5
  );

  modport slave (
    input  id_valid, id_opcode, id_ALUop, id_Branch, id_MemRead, id_MemWrite, id_RegWrite,
           id_MemToReg, id_ALUsrc, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2,
           id_rd, id_funct3, id_funct7b5, flush,
    output stall, ex_valid, ex_ALUop, ex_Branch, ex_MemRead, ex_MemWrite, ex_RegWrite,
           ex_MemToReg, ex_ALUsrc, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
           ex_rd, ex_funct3, ex_funct7b5
  );
endinterface

// File: rtl/id_ex_stage_reg_hazard.sv
// Combinational load-use hazard detect: a load in EX whose rd feeds a source the decode slot reads.
module load_use_hazard
  import rv_pkg::*;
#(
  parameter int REG_IDX_W = 5
) (
  input  logic [6:0]           id_opcode,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 ex_valid,
  input  logic                 ex_MemRead,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 flush,
  output logic                 hazard,
  output logic                 stall
);
  logic uses_rs1, uses_rs2;

  // Unused source fields of LUI/JAL/I-type hold immediate bits and must not match.
  assign uses_rs1 = !(id_opcode == OPC_LUI || id_opcode == OPC_JAL);
  assign uses_rs2 = (id_opcode == OPC_RTYPE) || (id_opcode == OPC_STORE) ||
                    (id_opcode == OPC_BRANCH);

  assign hazard = ex_valid && ex_MemRead && (ex_rd != '0) && id_valid &&
                  ((uses_rs1 && ex_rd == id_rs1) || (uses_rs2 && ex_rd == id_rs2));
  assign stall  = hazard && !flush;
endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion and branch flush.
// Optional IDEX_STALL_COUNT_EN adds a saturating stall_count output.
module id_ex_stage_reg
  import rv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  id_ex_stage_reg_if.slave  bus
`ifdef IDEX_STALL_COUNT_EN
  ,
  output logic [31:0]       stall_count
`endif
);
  localparam logic [XLEN-1:0]      ZERO_X = '0;
  localparam logic [REG_IDX_W-1:0] ZERO_R = '0;

  logic  hazard, stall;
  ctrl_t id_ctrl, ctrl_q;

  load_use_hazard #(.REG_IDX_W(REG_IDX_W)) u_hazard (
    .id_opcode  (bus.id_opcode),
    .id_valid   (bus.id_valid),
    .id_rs1     (bus.id_rs1),
    .id_rs2     (bus.id_rs2),
    .ex_valid   (bus.ex_valid),
    .ex_MemRead (ctrl_q.MemRead),
    .ex_rd      (bus.ex_rd),
    .flush      (bus.flush),
    .hazard     (hazard),
    .stall      (stall)
  );

  assign bus.stall = stall;

  always_comb begin
    id_ctrl = CTRL_BUBBLE;
    if (bus.id_valid)
      id_ctrl = '{ALUop: bus.id_ALUop, Branch: bus.id_Branch, MemRead: bus.id_MemRead,
                  MemWrite: bus.id_MemWrite, RegWrite: bus.id_RegWrite,
                  MemToReg: bus.id_MemToReg, ALUsrc: bus.id_ALUsrc};
  end

  // Reset, flush and hazard all produce the same all-zero bubble.
  always_ff @(posedge clk) begin
    if (reset || bus.flush || hazard) begin
      bus.ex_valid    <= 1'b0;
      ctrl_q          <= CTRL_BUBBLE;
      bus.ex_pc       <= ZERO_X;
      bus.ex_rs1_data <= ZERO_X;
      bus.ex_rs2_data <= ZERO_X;
      bus.ex_imm      <= ZERO_X;
      bus.ex_rs1      <= ZERO_R;
      bus.ex_rs2      <= ZERO_R;
      bus.ex_rd       <= ZERO_R;
      bus.ex_funct3   <= 3'b000;
      bus.ex_funct7b5 <= 1'b0;
    end else begin
      bus.ex_valid    <= bus.id_valid;
      ctrl_q          <= id_ctrl;
      bus.ex_pc       <= bus.id_pc;
      bus.ex_rs1_data <= bus.id_rs1_data;
      bus.ex_rs2_data <= bus.id_rs2_data;
      bus.ex_imm      <= bus.id_imm;
      bus.ex_rs1      <= bus.id_rs1;
      bus.ex_rs2      <= bus.id_rs2;
      bus.ex_rd       <= bus.id_rd;
      bus.ex_funct3   <= bus.id_funct3;
      bus.ex_funct7b5 <= bus.id_funct7b5;
    end
  end

  assign bus.ex_ALUop    = ctrl_q.ALUop;
  assign bus.ex_Branch   = ctrl_q.Branch;
  assign bus.ex_MemRead  = ctrl_q.MemRead;
  assign bus.ex_MemWrite = ctrl_q.MemWrite;
  assign bus.ex_RegWrite = ctrl_q.RegWrite;
  assign bus.ex_MemToReg = ctrl_q.MemToReg;
  assign bus.ex_ALUsrc   = ctrl_q.ALUsrc;

`ifdef IDEX_STALL_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_count <= '0;
    else if (stall && stall_count != 32'hFFFF_FFFF)
      stall_count <= stall_count + 32'd1;
  end
`endif
endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Pipeline register between decode (control unit, register file, immediate generator) and execute.
- Latches decoded control bits, operands and register indices each cycle.
- Detects load-use hazards and stalls fetch/decode while inserting a bubble.
- Accepts a flush from branch resolution. Consumed directly by the ALU control, ALU and forwarding logic.

Parameters:
- XLEN, 32, datapath width of PC, operands and immediate.
- REG_IDX_W, 5, register index width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  decode slot holds a real instruction.
- id_opcode  in  7  opcode of decoded instruction, used for operand-usage decode.
- id_ALUop  in  2  from control unit.
- id_Branch, id_MemRead, id_MemWrite, id_RegWrite, id_MemToReg, id_ALUsrc  in  1 each  from control unit.
- id_pc  in  XLEN  PC of decoded instruction.
- id_rs1_data, id_rs2_data, id_imm  in  XLEN  operands and immediate.
- id_rs1, id_rs2, id_rd  in  REG_IDX_W  register indices.
- id_funct3  in  3; id_funct7b5  in  1  ALU control inputs.
- flush  in  1  branch/jump taken, squash decode slot.
- stall  out  1  combinational; holds PC and IF/ID register.
- ex_valid  out  1.
- ex_ALUop  out  2.
- ex_Branch, ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemToReg, ex_ALUsrc  out  1 each.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN.
- ex_rs1, ex_rs2, ex_rd  out  REG_IDX_W.
- ex_funct3  out  3; ex_funct7b5  out  1.

Behaviour:
- Clocking: one clock `clk`; `reset` is synchronous and active-high. All ex_* outputs are registers and update on the rising edge of clk.
- Reset: every ex_* output is 0 (ALUop 2'b00, all control bits 0, data 0), so ex_valid=0.
- Latency: 1 cycle from id_* to ex_*.
- Operand usage, decoded from id_opcode:
  - uses_rs1 = 1 except for LUI (0110111) and JAL (1101111).
  - uses_rs2 = 1 only for R-type (0110011), STORE (0100011) and BRANCH (1100011).
- Load-use hazard, combinational:
  - hazard = ex_valid & ex_MemRead & (ex_rd != 0) & id_valid & ((uses_rs1 & ex_rd == id_rs1) | (uses_rs2 & ex_rd == id_rs2)).
  - stall = hazard & ~flush.
- Next-state priority:
  1. reset.
  2. flush: load a bubble.
  3. hazard: load a bubble.
  4. otherwise: load the id_* fields, with ex_valid = id_valid.
- Bubble definition: ex_valid=0, all control outputs 0 (including MemToReg; no X values ever propagate), data and index fields 0.
- When id_valid=0 and there is no flush, the register still loads, but control outputs are forced to 0.
- After a stall bubble the stalled instruction is re-presented by IF/ID. The hazard clears next cycle because ex_MemRead is then 0.
- Simultaneous flush and hazard: flush wins and stall=0, so fetch proceeds to the branch target.
- Writes to x0: rd=0 never raises a hazard.
- Reset asserted mid-stall: bubble state on the next edge; stall deasserts once reset takes effect (ex_valid=0).
- The state machine is implicit: NORMAL / BUBBLE, carried by ex_valid.

Optional Feature:
- Macro IDEX_STALL_COUNT_EN.
- When defined: adds output stall_count (32-bit). It is a counter of cycles with stall=1, reset to 0 by reset and saturating at 0xFFFFFFFF (no wrap).
- When not defined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants OPC_LOAD, OPC_STORE, OPC_RTYPE, OPC_BRANCH, OPC_IMM, OPC_LUI, OPC_JALR, OPC_JAL;
  - ALUop encodings;
  - a packed ctrl_t struct {ALUop, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUsrc} and a CTRL_BUBBLE constant (all zero).
- Sub-module load_use_hazard (purely combinational): computes uses_rs1, uses_rs2, hazard and stall from the id/ex indices, ex_MemRead, ex_valid and flush.

Test Plan:
- Reset, then release: all ex_* read 0 and stall=0. Then ADD x3,x1,x2 (opcode 0110011, rs1=1, rs2=2, rd=3) -> next cycle ex_valid=1, ex_ALUop=10, ex_RegWrite=1, ex_rd=3.
- LW x5,0(x1), then ADD x6,x5,x2 -> in the cycle the ADD is in decode, stall=1. Next cycle: bubble, ex_valid=0, controls 0. Following cycle: ADD latched, stall=0.
- LW x5 then LUI x5 (and separately LW x0 then ADD x6,x0,x2) -> stall stays 0 in both.
- LW x5 then ADDI x7,x1,4 where id_rs2 field=5 -> stall=0, because I-type does not use rs2.
- LW x5, then ADD x6,x5,x2 with flush=1 in the same cycle -> stall=0 and ex_valid=0 next cycle.
- Assert reset during a stall cycle -> next edge all ex_* are 0 and stall=0. With IDEX_STALL_COUNT_EN, stall_count goes 1→0.
